// File: rtl/pc_unit.sv
// pc_unit: fetch program counter with trap/redirect selection, halt control,
// target-alignment checking and a redirect epoch for discarding stale fetches.
module pc_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000,
  parameter bit              C_EXT        = 1'b0,
  parameter int              EPOCH_W      = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               fetch_valid,
  input  logic               fetch_ready,
  output logic [XLEN-1:0]    pc_out,
  output logic [EPOCH_W-1:0] epoch,
  input  logic               ilen16,
  input  logic               redir_valid,
  input  logic [XLEN-1:0]    redir_pc,
  input  logic               branch,
  input  logic               isjalr,
  input  logic [XLEN-1:0]    offset,
  input  logic [XLEN-1:0]    jalr_reg,
  input  logic               trap_valid,
  input  logic [XLEN-1:0]    trap_vector,
  input  logic               halt_req,
  output logic               halted,
  output logic               misalign_err
);
  typedef enum logic [1:0] {BOOT, RUN, HALT, WAIT} state_t;
  state_t               state_q, state_d;
  logic [XLEN-1:0]      pc_q, pc_d, target, step;
  logic [EPOCH_W-1:0]   epoch_q, epoch_d, epoch_inc;
  logic                 fv_q, halted_q, mis_q, mis_d, fire, taken, bad;
  assign fire      = fv_q & fetch_ready;
  assign taken     = redir_valid & (branch | isjalr);
  assign target    = isjalr ? (jalr_reg + offset) & ~XLEN'(1) : redir_pc + offset;
  assign bad       = C_EXT ? target[0] : |target[1:0];
  assign step      = (C_EXT && ilen16) ? XLEN'(2) : XLEN'(4);
  assign epoch_inc = epoch_q + EPOCH_W'(1);
  // A trap or taken redirect cancels any pending request, so halt may follow it
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epoch_d = epoch_q;
    mis_d   = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      WAIT: begin
        pc_d    = trap_valid ? trap_vector : pc_q;
        epoch_d = trap_valid ? epoch_inc : epoch_q;
        state_d = trap_valid ? RUN : WAIT;
      end
      default: begin
        if (trap_valid) begin
          pc_d    = trap_vector;
          epoch_d = epoch_inc;
          state_d = (state_q == HALT || halt_req) ? HALT : RUN;
        end else if (taken) begin
          epoch_d = epoch_inc;
          mis_d   = bad;
          pc_d    = bad ? pc_q : target;
          state_d = bad ? WAIT : halt_req ? HALT : RUN;
        end else if (state_q == HALT) begin
          state_d = halt_req ? HALT : RUN;
        end else if (fire) begin
          pc_d    = pc_q + step;
          state_d = halt_req ? HALT : RUN;
        end
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= BOOT;
      pc_q     <= RESET_VECTOR;
      epoch_q  <= '0;
      fv_q     <= 1'b0;
      halted_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      epoch_q  <= epoch_d;
      fv_q     <= state_d == RUN;
      halted_q <= state_d == HALT;
      mis_q    <= mis_d;
    end
  end
  assign fetch_valid  = fv_q;
  assign pc_out       = pc_q;
  assign epoch        = epoch_q;
  assign halted       = halted_q;
  assign misalign_err = mis_q;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: two pc_unit instances (C_EXT=0 and C_EXT=1) sharing stimulus,
// checked every cycle against a behavioural model plus directed literal checks.
module tb_pc_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        fetch_ready = 1'b0, ilen16 = 1'b0, redir_valid = 1'b0, branch = 1'b0;
  logic        isjalr = 1'b0, trap_valid = 1'b0, halt_req = 1'b0;
  logic [31:0] redir_pc = '0, offset = '0, jalr_reg = '0, trap_vector = '0;
  logic        fv0, fv1, hl0, hl1, me0, me1;
  logic [31:0] pc0, pc1;
  logic [1:0]  ep0, ep1;
  int          n_cmp = 0, n_err = 0;

  pc_unit #(.C_EXT(1'b0)) u0 (
    .clk(clk), .rst(rst), .fetch_valid(fv0), .fetch_ready(fetch_ready), .pc_out(pc0),
    .epoch(ep0), .ilen16(ilen16), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .branch(branch), .isjalr(isjalr), .offset(offset), .jalr_reg(jalr_reg),
    .trap_valid(trap_valid), .trap_vector(trap_vector), .halt_req(halt_req),
    .halted(hl0), .misalign_err(me0));
  pc_unit #(.RESET_VECTOR(32'h0), .C_EXT(1'b1)) u1 (
    .clk(clk), .rst(rst), .fetch_valid(fv1), .fetch_ready(fetch_ready), .pc_out(pc1),
    .epoch(ep1), .ilen16(ilen16), .redir_valid(redir_valid), .redir_pc(redir_pc),
    .branch(branch), .isjalr(isjalr), .offset(offset), .jalr_reg(jalr_reg),
    .trap_valid(trap_valid), .trap_vector(trap_vector), .halt_req(halt_req),
    .halted(hl1), .misalign_err(me1));

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode 0 boot, 1 fetching, 2 halted, 3 parked after bad target
  typedef struct {logic [31:0] pc; logic [1:0] ep; int mode; bit mis;} m_t;
  m_t m0, m1;

  function automatic m_t fresh(logic [31:0] rv);
    m_t n;
    n.pc = rv; n.ep = 0; n.mode = 0; n.mis = 0;
    return n;
  endfunction

  function automatic m_t adv(m_t s, bit c);
    m_t n = s;
    logic [31:0] tgt;
    int unsigned algn = c ? 2 : 4;
    n.mis = 0;
    tgt = isjalr ? ((jalr_reg + offset) & 32'hFFFF_FFFE) : redir_pc + offset;
    if (s.mode == 0) n.mode = 1;
    else if (s.mode == 3) begin
      if (trap_valid) begin n.pc = trap_vector; n.ep++; n.mode = 1; end
    end else if (trap_valid) begin
      n.pc = trap_vector; n.ep++;
      n.mode = (s.mode == 2 || halt_req) ? 2 : 1;
    end else if (redir_valid && (branch || isjalr)) begin
      n.ep++;
      if (tgt % algn != 0) begin n.mis = 1; n.mode = 3; end
      else begin n.pc = tgt; n.mode = halt_req ? 2 : 1; end
    end else if (s.mode == 2) n.mode = halt_req ? 2 : 1;
    else if (fetch_ready) begin
      n.pc = n.pc + ((c && ilen16) ? 32'd2 : 32'd4);
      n.mode = halt_req ? 2 : 1;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst)
    if (!rst) begin m0 <= fresh(32'h8000_0000); m1 <= fresh(32'h0); end
    else begin m0 <= adv(m0, 1'b0); m1 <= adv(m1, 1'b1); end

  bit cmp_en = 1'b0;
  always @(negedge clk) if (cmp_en) begin
    chk("m0.fv", 32'(fv0), 32'(m0.mode == 1));
    chk("m0.halted", 32'(hl0), 32'(m0.mode == 2));
    chk("m0.mis", 32'(me0), 32'(m0.mis));
    chk("m0.pc", pc0, m0.pc);
    chk("m0.epoch", 32'(ep0), 32'(m0.ep));
    chk("m1.fv", 32'(fv1), 32'(m1.mode == 1));
    chk("m1.halted", 32'(hl1), 32'(m1.mode == 2));
    chk("m1.mis", 32'(me1), 32'(m1.mis));
    chk("m1.pc", pc1, m1.pc);
    chk("m1.epoch", 32'(ep1), 32'(m1.ep));
  end

  task automatic clr();
    redir_valid = 0; branch = 0; isjalr = 0; trap_valid = 0; halt_req = 0;
    redir_pc = 0; offset = 0; jalr_reg = 0; trap_vector = 0; ilen16 = 0;
  endtask

  task automatic cyc(); @(negedge clk); endtask

  initial begin
    #1 rst = 1'b0;
    cmp_en = 1'b1;
    cyc();
    chk("rst.pc", pc0, 32'h8000_0000); chk("rst.fv", 32'(fv0), 0);
    chk("rst.ep", 32'(ep0), 0); chk("rst.halt", 32'(hl0), 0); chk("rst.mis", 32'(me0), 0);
    cyc(); rst = 1'b1; fetch_ready = 1'b1;
    chk("boot.fv", 32'(fv0), 0);
    cyc(); chk("boot.fv1", 32'(fv0), 1); chk("boot.pc0", pc0, 32'h8000_0000);
    cyc(); chk("seq.pc4", pc0, 32'h8000_0004);
    cyc(); chk("seq.pc8", pc0, 32'h8000_0008); chk("seq.ep", 32'(ep0), 0);
    fetch_ready = 0;
    cyc(); chk("bp.hold", pc0, 32'h8000_0008); chk("bp.fv", 32'(fv0), 1);
    redir_valid = 1; branch = 1; redir_pc = 32'h8000_0000; offset = 32'h40;
    cyc(); chk("br.pc", pc0, 32'h8000_0040); chk("br.ep", 32'(ep0), 1);
    clr(); trap_valid = 1; trap_vector = 32'h100; redir_valid = 1; isjalr = 1; jalr_reg = 32'h2001;
    cyc(); chk("trapwin.pc", pc0, 32'h100); chk("trapwin.ep", 32'(ep0), 2);
    clr(); redir_valid = 1; isjalr = 1; jalr_reg = 32'h2001;
    cyc(); chk("jalr.pc", pc0, 32'h2000); chk("jalr.ep", 32'(ep0), 3);
    clr(); redir_valid = 1; branch = 1; redir_pc = 32'h8000_0000; offset = 32'h42;
    cyc(); chk("mis.pulse", 32'(me0), 1); chk("mis.fv", 32'(fv0), 0);
    chk("mis.pc", pc0, 32'h2000); chk("mis.epwrap", 32'(ep0), 0);
    chk("c1.pc42", pc1, 32'h8000_0042); chk("c1.nomis", 32'(me1), 0);
    clr();
    cyc(); chk("wait.mis", 32'(me0), 0); chk("wait.fv", 32'(fv0), 0);
    trap_valid = 1; trap_vector = 32'h0;
    cyc(); chk("wait.exit", 32'(fv0), 1); chk("wait.pc", pc0, 32'h0);
    clr(); fetch_ready = 1; ilen16 = 1;
    cyc(); chk("c16.a", pc1, 32'h2); chk("c0.a", pc0, 32'h4);
    ilen16 = 0;
    cyc(); chk("c16.b", pc1, 32'h6);
    ilen16 = 1;
    cyc(); chk("c16.c", pc1, 32'h8); chk("c0.c", pc0, 32'hC);
    clr(); trap_valid = 1; trap_vector = 32'hFFFF_FFFC;
    cyc(); chk("wrap.a", pc0, 32'hFFFF_FFFC);
    clr();
    cyc(); chk("wrap.b", pc0, 32'h0); chk("wrap.c1", pc1, 32'h0);
    fetch_ready = 0; halt_req = 1;
    cyc(); chk("hpend.h", 32'(hl0), 0); chk("hpend.fv", 32'(fv0), 1);
    cyc(); chk("hpend.h2", 32'(hl0), 0);
    fetch_ready = 1;
    cyc(); chk("halt.h", 32'(hl0), 1); chk("halt.fv", 32'(fv0), 0); chk("halt.pc", pc0, 32'h4);
    cyc(); chk("halt.stay", 32'(hl0), 1); chk("halt.pcs", pc0, 32'h4);
    halt_req = 0;
    cyc(); chk("res.h", 32'(hl0), 0); chk("res.fv", 32'(fv0), 1); chk("res.pc", pc0, 32'h4);
    cyc(); chk("res.step", pc0, 32'h8);
    for (int i = 0; i < 3000; i++) begin
      redir_valid = $urandom % 5 == 0;
      branch      = 1'($urandom);
      isjalr      = $urandom % 3 == 0;
      trap_valid  = $urandom % 25 == 0;
      if ($urandom % 10 == 0) halt_req = ~halt_req;
      fetch_ready = $urandom % 10 < 7;
      ilen16      = 1'($urandom);
      offset      = 32'($urandom_range(0, 511)) - 32'd256;
      if ($urandom % 4 != 0) offset[1:0] = 2'b00;
      redir_pc    = $urandom & 32'hFFFF_FFFC;
      jalr_reg    = $urandom;
      trap_vector = $urandom & (($urandom % 8 == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      if ($urandom % 400 == 0) begin
        #2 rst = 1'b0;
        #1 chk("async.pc", pc0, 32'h8000_0000); chk("async.fv", 32'(fv0), 0);
        chk("async.ep", 32'(ep0), 0);
        cyc(); rst = 1'b1;
      end else cyc();
    end
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
